// File: rtl/bsg_power_iso_pkg.sv
// Shared types for the power/isolation sequencer: state encoding (also used by a future status CSR),
// decoded output bundle, and small constant helpers.
package bsg_power_iso_pkg;

    localparam int bsg_power_iso_state_width_gp = 3;

    localparam logic [bsg_power_iso_state_width_gp-1:0] bsg_power_iso_off_enc_gp    = 3'd0;
    localparam logic [bsg_power_iso_state_width_gp-1:0] bsg_power_iso_ramp_enc_gp   = 3'd1;
    localparam logic [bsg_power_iso_state_width_gp-1:0] bsg_power_iso_settle_enc_gp = 3'd2;
    localparam logic [bsg_power_iso_state_width_gp-1:0] bsg_power_iso_on_enc_gp     = 3'd3;
    localparam logic [bsg_power_iso_state_width_gp-1:0] bsg_power_iso_drain_enc_gp  = 3'd4;
    localparam logic [bsg_power_iso_state_width_gp-1:0] bsg_power_iso_fault_enc_gp  = 3'd5;

    typedef enum logic [bsg_power_iso_state_width_gp-1:0] {
        OFF    = bsg_power_iso_off_enc_gp,
        RAMP   = bsg_power_iso_ramp_enc_gp,
        SETTLE = bsg_power_iso_settle_enc_gp,
        ON     = bsg_power_iso_on_enc_gp,
        DRAIN  = bsg_power_iso_drain_enc_gp,
        FAULT  = bsg_power_iso_fault_enc_gp
    } bsg_power_iso_state_e;

    typedef struct packed {
        logic pwr_switch_en;
        logic iso_en;
        logic busy;
        logic fault;
    } bsg_power_iso_out_s;

    function automatic int bsg_power_iso_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bsg_power_iso_out_s bsg_power_iso_decode(input bsg_power_iso_state_e s);
        bsg_power_iso_out_s o;
        o = '0;
        case (s)
            RAMP, SETTLE, DRAIN: begin
                o.pwr_switch_en = 1'b1;
                o.busy          = 1'b1;
            end
            ON: begin
                o.pwr_switch_en = 1'b1;
                o.iso_en        = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bsg_power_iso_seq_timer.sv
// Loadable down-counter with zero flag; load wins over decrement and the count holds at zero.
module bsg_power_iso_seq_timer #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    output logic               zero_o
);

    logic [width_p-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_power_iso_sequencer.sv
// Power-switch and isolation sequencer driving v0_en_i of bsg_level_shift_up_down_source.
// Optional RAMP power-good timeout: define BSG_POWER_ISO_SEQUENCER_TIMEOUT_EN.
// state  | meaning
// OFF    | switch open, clamped         RAMP  | switch closed, awaiting power-good
// SETTLE | supply good, letting settle  ON    | isolation released, domain usable
// DRAIN  | clamped, switch still closed FAULT | switch open, waiting for request to drop
module bsg_power_iso_sequencer
    import bsg_power_iso_pkg::*;
#(
    parameter int settle_cycles_p  = 4,
    parameter int drain_cycles_p   = 2,
    parameter int timeout_cycles_p = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic power_on_req_i,
    input  logic power_good_i,
    output logic pwr_switch_en_o,
    output logic iso_en_o,
    output logic on_o,
    output logic busy_o,
    output logic fault_o
);

    localparam int cnt_width_lp =
        $clog2(bsg_power_iso_max3(settle_cycles_p, drain_cycles_p, timeout_cycles_p) + 1);

    bsg_power_iso_state_e state_q, state_d;
    bsg_power_iso_out_s   out_q;
    logic                 load;
    logic [cnt_width_lp-1:0] load_val;
    logic                 timer_zero;

    bsg_power_iso_seq_timer #(.width_p(cnt_width_lp)) timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .load_val_i (load_val),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            OFF: begin
                if (power_on_req_i) begin
                    state_d = RAMP;
`ifdef BSG_POWER_ISO_SEQUENCER_TIMEOUT_EN
                    load     = 1'b1;
                    load_val = cnt_width_lp'(timeout_cycles_p - 1);
`endif
                end
            end
            RAMP: begin
                if (!power_on_req_i) begin
                    state_d = OFF;
                end else if (power_good_i) begin
                    state_d  = SETTLE;
                    load     = 1'b1;
                    load_val = cnt_width_lp'(settle_cycles_p - 1);
                end
`ifdef BSG_POWER_ISO_SEQUENCER_TIMEOUT_EN
                else if (timer_zero) begin
                    state_d = FAULT;
                end
`endif
            end
            SETTLE: begin
                if (!power_on_req_i)   state_d = OFF;
                else if (!power_good_i) state_d = FAULT;
                else if (timer_zero)    state_d = ON;
            end
            // Brownout outranks a simultaneous request drop.
            ON: begin
                if (!power_good_i) begin
                    state_d = FAULT;
                end else if (!power_on_req_i) begin
                    state_d  = DRAIN;
                    load     = 1'b1;
                    load_val = cnt_width_lp'(drain_cycles_p - 1);
                end
            end
            DRAIN: begin
                if (timer_zero) state_d = OFF;
            end
            FAULT: begin
                if (!power_on_req_i) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= OFF;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= bsg_power_iso_decode(state_d);
        end
    end

    assign pwr_switch_en_o = out_q.pwr_switch_en;
    assign iso_en_o        = out_q.iso_en;
    assign on_o            = out_q.iso_en;
    assign busy_o          = out_q.busy;
    assign fault_o         = out_q.fault;

endmodule

// File: tb/tb_bsg_power_iso_sequencer.sv
// Directed + randomized bench for bsg_power_iso_sequencer against a deadline-based reference model.
module tb_bsg_power_iso_sequencer;

    localparam int SETTLE  = 4;
    localparam int DRAIN   = 2;
    localparam int TIMEOUT = 64;

    localparam int P_OFF = 0, P_RAMP = 1, P_SETTLE = 2, P_ON = 3, P_DRAIN = 4, P_FAULT = 5;

    logic clk;
    logic reset_i, req_i, pg_i;
    logic sw_o, iso_o, on_o, busy_o, fault_o;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int m_phase    = P_OFF;
    int m_until    = 0;

    bsg_power_iso_sequencer #(
        .settle_cycles_p  (SETTLE),
        .drain_cycles_p   (DRAIN),
        .timeout_cycles_p (TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .power_on_req_i  (req_i),
        .power_good_i    (pg_i),
        .pwr_switch_en_o (sw_o),
        .iso_en_o        (iso_o),
        .on_o            (on_o),
        .busy_o          (busy_o),
        .fault_o         (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model works with absolute deadlines: a timed phase ends at the edge whose index equals m_until.
    task automatic model_step(input bit rst, input bit req, input bit pg);
        if (rst) begin
            m_phase = P_OFF;
        end else begin
            case (m_phase)
                P_OFF: if (req) begin
                    m_phase = P_RAMP;
                    m_until = cyc + TIMEOUT;
                end
                P_RAMP: begin
                    if (!req) m_phase = P_OFF;
                    else if (pg) begin
                        m_phase = P_SETTLE;
                        m_until = cyc + SETTLE;
                    end
`ifdef BSG_POWER_ISO_SEQUENCER_TIMEOUT_EN
                    else if (cyc >= m_until) m_phase = P_FAULT;
`endif
                end
                P_SETTLE: begin
                    if (!req) m_phase = P_OFF;
                    else if (!pg) m_phase = P_FAULT;
                    else if (cyc >= m_until) m_phase = P_ON;
                end
                P_ON: begin
                    if (!pg) m_phase = P_FAULT;
                    else if (!req) begin
                        m_phase = P_DRAIN;
                        m_until = cyc + DRAIN;
                    end
                end
                P_DRAIN: if (cyc >= m_until) m_phase = P_OFF;
                default: if (!req) m_phase = P_OFF;
            endcase
        end
    endtask

    task automatic tick(input bit rst, input bit req, input bit pg);
        bit e_sw, e_iso, e_busy, e_fault;
        reset_i = rst;
        req_i   = req;
        pg_i    = pg;
        @(posedge clk);
        model_step(rst, req, pg);
        cyc++;
        #1;
        e_sw    = (m_phase == P_RAMP) || (m_phase == P_SETTLE) || (m_phase == P_ON) || (m_phase == P_DRAIN);
        e_iso   = (m_phase == P_ON);
        e_busy  = (m_phase == P_RAMP) || (m_phase == P_SETTLE) || (m_phase == P_DRAIN);
        e_fault = (m_phase == P_FAULT);
        chk("model_switch", sw_o, e_sw);
        chk("model_iso", iso_o, e_iso);
        chk("model_on", on_o, e_iso);
        chk("model_busy", busy_o, e_busy);
        chk("model_fault", fault_o, e_fault);
    endtask

    task automatic power_up(input int budget);
        int n = 0;
        while (iso_o !== 1'b1 && n < budget) begin
            tick(0, 1, 1);
            n++;
        end
        chk("reach_on", iso_o, 1'b1);
    endtask

    initial begin
        bit saw_iso;
        bit req, pg;
        reset_i = 1'b1;
        req_i   = 1'b0;
        pg_i    = 1'b0;

        // reset held with request high
        tick(1, 1, 0);
        tick(1, 1, 0);
        chk("rst_switch", sw_o, 1'b0);
        chk("rst_iso", iso_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_fault", fault_o, 1'b0);
        tick(0, 1, 0);
        chk("post_rst_ramp_switch", sw_o, 1'b1);
        chk("post_rst_ramp_busy", busy_o, 1'b1);
        tick(0, 0, 0);
        chk("ramp_abort_switch", sw_o, 1'b0);

        // power-up: req from edge 0, power-good from edge 3; outputs after edge k are cycle k+1
        for (int k = 0; k < 20; k++) begin
            tick(0, 1, (k >= 3));
            chk("pu_switch", sw_o, 1'b1);
            chk("pu_busy", busy_o, (k + 1 <= 7));
            chk("pu_iso", iso_o, (k + 1 >= 8));
        end
        // power-down at edge 20, request re-asserted during drain is ignored
        tick(0, 0, 1);
        chk("pd_iso21", iso_o, 1'b0);
        chk("pd_switch21", sw_o, 1'b1);
        chk("pd_busy21", busy_o, 1'b1);
        tick(0, 1, 1);
        chk("pd_switch22", sw_o, 1'b1);
        tick(0, 1, 1);
        chk("pd_switch23", sw_o, 1'b0);
        chk("pd_busy23", busy_o, 1'b0);
        tick(0, 1, 1);
        chk("pd_reramp", sw_o, 1'b1);

        // abort during settle
        saw_iso = 1'b0;
        tick(0, 1, 1);
        saw_iso |= iso_o;
        tick(0, 1, 1);
        saw_iso |= iso_o;
        tick(0, 0, 1);
        saw_iso |= iso_o;
        chk("abort_switch", sw_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_never_iso", saw_iso, 1'b0);

        // brownout from ON
        power_up(20);
        tick(0, 1, 0);
        chk("bo_iso", iso_o, 1'b0);
        chk("bo_switch", sw_o, 1'b0);
        chk("bo_fault", fault_o, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 1);
            chk("bo_fault_sticky", fault_o, 1'b1);
        end
        tick(0, 0, 1);
        chk("bo_fault_clear", fault_o, 1'b0);

        // brownout together with request drop goes to FAULT, not DRAIN
        power_up(20);
        tick(0, 0, 0);
        chk("bo_prio_fault", fault_o, 1'b1);
        chk("bo_prio_busy", busy_o, 1'b0);
        tick(0, 0, 0);

        // reset mid-operation opens switch without draining
        power_up(20);
        tick(1, 1, 1);
        chk("midrst_switch", sw_o, 1'b0);
        chk("midrst_iso", iso_o, 1'b0);
        tick(0, 0, 0);

        // RAMP with power-good held low
        for (int j = 0; j < 200; j++) begin
            tick(0, 1, 0);
`ifdef BSG_POWER_ISO_SEQUENCER_TIMEOUT_EN
            if (j == 63) chk("to_not_yet", fault_o, 1'b0);
            if (j == 64) chk("to_fault_at_65", fault_o, 1'b1);
`else
            if (j == 199) begin
                chk("no_to_switch", sw_o, 1'b1);
                chk("no_to_busy", busy_o, 1'b1);
                chk("no_to_fault", fault_o, 1'b0);
            end
`endif
        end
        tick(0, 0, 0);

        // randomized traffic, slowly varying inputs so long sequences are reached
        req = 1'b0;
        pg  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) req = ~req;
            if ($urandom_range(0, 9) == 0)  pg  = ~pg;
            tick(($urandom_range(0, 99) == 0), req, pg);
            chk("inv_iso_implies_switch", (iso_o & ~sw_o), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bsg_power_iso_sequencer.md
Name: bsg_power_iso_sequencer

Overview:
Sequencer that generates the enable (v0_en_i) for a bank of isolating level shifters at a power-domain boundary, plus the domain's power-switch enable.
- Power-up order: switch on, wait for power-good, settle, then release isolation.
- Power-down order: clamp isolation first, drain, then switch off.
- Sits in the always-on domain, directly upstream of bsg_level_shift_up_down_source; iso_en_o drives its v0_en_i.

Parameters:
settle_cycles_p, 4, cycles after power_good_i before isolation is released (>=1)
drain_cycles_p, 2, cycles isolation stays clamped before the switch opens (>=1)
timeout_cycles_p, 64, max cycles in RAMP waiting for power_good_i (used only with the optional feature)

Ports:
clk_i  input  1  clock, always-on domain
reset_i  input  1  synchronous, active-high reset
power_on_req_i  input  1  level request: 1 = domain on, 0 = domain off
power_good_i  input  1  domain supply-good indication, already synchronized
pwr_switch_en_o  output  1  power-switch enable for the domain
iso_en_o  output  1  isolation enable to level shifters: 1 = pass data, 0 = clamp outputs to 0
on_o  output  1  domain is usable; equals iso_en_o
busy_o  output  1  sequencer is in a transient state (RAMP, SETTLE, DRAIN)
fault_o  output  1  power fault; sticky until the request drops

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous and active-high. All outputs are registered and decoded from state.
- Reset: state OFF; pwr_switch_en_o=0, iso_en_o=0, on_o=0, busy_o=0, fault_o=0; counter=0.
- Reset mid-operation: on the next edge, everything returns to OFF values. Isolation clamps and the switch opens in the same cycle (reset is the only path that opens the switch without draining).
- States: OFF, RAMP, SETTLE, ON, DRAIN, FAULT.
- OFF: switch=0, iso=0. power_on_req_i=1 -> RAMP.
- RAMP: switch=1, iso=0, busy=1.
  - power_on_req_i=0 -> OFF.
  - Else power_good_i=1 -> SETTLE, counter loaded with settle_cycles_p-1.
- SETTLE: switch=1, iso=0, busy=1; counter decrements each cycle.
  - power_on_req_i=0 -> OFF (isolation never released).
  - power_good_i=0 -> FAULT.
  - Counter==0 -> ON.
  - Net effect: exactly settle_cycles_p cycles in SETTLE.
- ON: switch=1, iso=1, on=1.
  - power_good_i=0 (brownout) -> FAULT; this has priority over the request.
  - Else power_on_req_i=0 -> DRAIN, counter loaded with drain_cycles_p-1.
- DRAIN: switch=1, iso=0, busy=1; counter decrements.
  - Counter==0 -> OFF.
  - Request re-asserted during DRAIN is ignored until OFF; from OFF the normal transition to RAMP follows.
- FAULT: switch=0, iso=0, fault=1. Stays until power_on_req_i=0, then -> OFF; fault_o clears on entry to OFF.
- Latency: request high at edge N gives switch high at N+1. power_good_i sampled high at edge M gives iso_en_o high at M+1+settle_cycles_p.
- Invariant: iso_en_o=1 implies pwr_switch_en_o=1 and state==ON.
- Counter width: `$clog2(max(settle_cycles_p, drain_cycles_p, timeout_cycles_p)+1)`. A single shared counter is reloaded on each state entry that uses it.

Optional Feature:
Macro BSG_POWER_ISO_SEQUENCER_TIMEOUT_EN.
- Defined: counter loads timeout_cycles_p-1 on entry to RAMP. If power_good_i is still 0 when the counter reaches 0 -> FAULT.
- Undefined: RAMP waits indefinitely; the timeout logic and parameter are unused. FAULT remains reachable via loss of power_good_i in SETTLE or ON.

Decomposition:
- Shared package bsg_power_iso_pkg holds:
  - enum bsg_power_iso_state_e {OFF, RAMP, SETTLE, ON, DRAIN, FAULT}, 3 bits;
  - encoding constants shared with a future status CSR.
- One natural sub-module: bsg_power_iso_seq_timer, a loadable down-counter with a zero flag. Everything else is a single FSM in the top module.

Test Plan:
- Reset: assert reset_i 2 cycles with power_on_req_i=1 -> all outputs 0; state OFF the cycle after reset drops, then RAMP.
- Power-up (settle=4): req=1 at cycle 0, power_good_i=1 from cycle 3 -> switch=1 from cycle 1, busy=1 cycles 1-7, iso_en_o=on_o=1 at cycle 8.
- Power-down (drain=2): from ON, drop req at cycle 20 -> iso_en_o=0 at 21, switch=0 at 23, busy=0 at 23.
- Abort: drop req during SETTLE -> next cycle OFF, switch=0, iso_en_o never 1.
- Brownout: in ON, power_good_i=0 for 1 cycle -> next cycle iso=0, switch=0, fault=1. fault stays with req=1 and clears one cycle after req=0.
- Timeout (macro defined, timeout=64): req=1, power_good_i held 0 -> fault_o=1 exactly 65 cycles after req sampled. With macro undefined -> stays in RAMP at cycle 200.
